// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier family: digit and FSM
// encodings plus radix-4 recoding helpers. The parallel encoder uses the
// same package.
package booth_pkg;

    // Radix-4 Booth digit selected from one overlapping multiplier triplet
    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG2,
        NEG1
    } booth_digit_t;

    // Sequencer states of the iterative multiplier
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mult_state_t;

    // Number of radix-4 digits needed to cover a signed operand of 'width' bits
    function automatic int num_groups(input int width);
        return (width + 1) / 2;
    endfunction

    // Recode one triplet {b[2i+2], b[2i+1], b[2i]} into its Booth digit
    function automatic booth_digit_t booth_decode(input logic [2:0] t);
        booth_digit_t d;
        case (t)
            3'b001, 3'b010: d = POS1;
            3'b011:         d = POS2;
            3'b100:         d = NEG2;
            3'b101, 3'b110: d = NEG1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// Operand/result bus of the iterative Booth multiplier.
//
// Handshake rules (both channels):
//   - A transfer happens on a rising clk edge where valid && ready are both 1.
//   - Once valid is raised it stays high, with its payload unchanged, until the
//     transfer edge. ready may be raised or lowered at any time and never
//     depends combinationally on valid.
//   - Input channel:  in_valid/in_ready carry multiplicand and multiplier.
//   - Output channel: out_valid/out_ready carry product.
// busy and state are status outputs; state exposes the sequencer encoding.
interface booth_mult_seq_if #(
    parameter int DATA_WIDTH = 32
);
    import booth_pkg::*;

    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_WIDTH-1:0]     multiplicand;
    logic [DATA_WIDTH-1:0]     multiplier;
    logic                      out_valid;
    logic                      out_ready;
    logic [2*DATA_WIDTH-1:0]   product;
    logic                      busy;
    mult_state_t               state;

    // Multiplier side
    modport slave (
        input  in_valid,
        input  multiplicand,
        input  multiplier,
        input  out_ready,
        output in_ready,
        output out_valid,
        output product,
        output busy,
        output state
    );

    // Issuing stage / result consumer side
    modport master (
        output in_valid,
        output multiplicand,
        output multiplier,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  product,
        input  busy,
        input  state
    );

endinterface

// File: rtl/booth_digit_select.sv
// Combinational Booth digit selection: maps one multiplier triplet to the
// signed multiple of A (0, +-A, +-2A), already at accumulator width.
module booth_digit_select #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]              triplet,
    input  logic [2*DATA_WIDTH-1:0] a,
    output logic [2*DATA_WIDTH-1:0] term
);
    import booth_pkg::*;

    localparam int PW = 2 * DATA_WIDTH;

    logic [PW-1:0] a2;

    assign a2 = {a[PW-2:0], 1'b0};

    // Pick the multiple of A named by the recoded digit (two's complement negate)
    always_comb begin
        term = '0;
        case (booth_decode(triplet))
            POS1:    term = a;
            POS2:    term = a2;
            NEG2:    term = -a2;
            NEG1:    term = -a;
            default: term = '0;
        endcase
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative signed radix-4 Booth multiplier. One Booth digit is retired per
// clock into a 2*DATA_WIDTH accumulator; latency is num_groups(DATA_WIDTH)
// cycles from operand acceptance to out_valid.
//
// Instead of shifting each term by 2*i, the latched multiplicand is shifted
// left by two and the extended multiplier right by two every RUN cycle, so the
// active triplet is always b_reg[2:0] and the selected term is already aligned.
// Truncation of the shifted multiplicand is harmless: the sum is taken
// modulo 2^(2*DATA_WIDTH) anyway.
//
// The interface instance must be parameterised with the same DATA_WIDTH.
module booth_mult_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    booth_mult_seq_if.slave bus
);
    import booth_pkg::*;

    localparam int PW = 2 * DATA_WIDTH;
    localparam int NG = num_groups(DATA_WIDTH);
    // Extended multiplier: {sign pad if odd width, B, 1'b0}
    localparam int BW = 2 * NG + 1;
    localparam int CW = (NG > 1) ? $clog2(NG) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NG - 1);

    mult_state_t   state_q;
    mult_state_t   state_d;
    logic          load;
    logic          step;
    logic          last;

    logic [PW-1:0] a_ext;
    logic [BW-1:0] b_ext;
    logic [PW-1:0] a_reg;
    logic [BW-1:0] b_reg;
    logic [PW-1:0] acc;
    logic [PW-1:0] term;
    logic [CW-1:0] cnt;

    // Sign-extend both operands into their working formats for the load
    always_comb begin
        a_ext                   = {PW{bus.multiplicand[DATA_WIDTH-1]}};
        a_ext[DATA_WIDTH-1:0]   = bus.multiplicand;
        b_ext                   = {BW{bus.multiplier[DATA_WIDTH-1]}};
        b_ext[DATA_WIDTH:1]     = bus.multiplier;
        b_ext[0]                = 1'b0;
    end

    assign last = (cnt == LAST_CNT);

    // Sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencer next state and datapath strobes
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    booth_digit_select #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_digit_select (
        .triplet(b_reg[2:0]),
        .a      (a_reg),
        .term   (term)
    );

    // Operand latch, per-digit shift and accumulate, digit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (load) begin
            a_reg <= a_ext;
            b_reg <= b_ext;
            acc   <= '0;
            cnt   <= '0;
        end else if (step) begin
            acc   <= acc + term;
            a_reg <= {a_reg[PW-3:0], 2'b00};
            b_reg <= {2'b00, b_reg[BW-1:2]};
            cnt   <= cnt + CW'(1);
        end
    end

    // All outputs decode registered state only
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.product   = acc;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: directed 8-bit and 7-bit cases plus randomized
// 32-bit traffic. Stimulus pushes expected products into per-width queues;
// independent monitors pop and compare on every output transfer.
module tb_booth_mult_seq;
    import booth_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    booth_mult_seq_if #(.DATA_WIDTH(8))  if8 ();
    booth_mult_seq_if #(.DATA_WIDTH(7))  if7 ();
    booth_mult_seq_if #(.DATA_WIDTH(32)) if32 ();

    booth_mult_seq #(.DATA_WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
    booth_mult_seq #(.DATA_WIDTH(7))  dut7  (.clk(clk), .rst(rst), .bus(if7.slave));
    booth_mult_seq #(.DATA_WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(if32.slave));

    localparam int N_RAND = 3000;

    int checks   = 0;
    int failures = 0;
    int got32    = 0;
    bit done     = 1'b0;

    logic [15:0] exp8_q[$];
    logic [13:0] exp7_q[$];
    logic [63:0] exp32_q[$];

    // ---------------- reference model ----------------
    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[15:0];
    endfunction

    function automatic logic [13:0] ref7(input logic [6:0] a, input logic [6:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[13:0];
    endfunction

    function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out at %0t", name, $time);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!rst && if8.out_valid && if8.out_ready) begin
            if (exp8_q.size() == 0) begin
                timeout("unexpected_product8");
            end else begin
                check("product8", 64'(if8.product), 64'(exp8_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && if7.out_valid && if7.out_ready) begin
            if (exp7_q.size() == 0) begin
                timeout("unexpected_product7");
            end else begin
                check("product7", 64'(if7.product), 64'(exp7_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && if32.out_valid && if32.out_ready) begin
            got32++;
            if (exp32_q.size() == 0) begin
                timeout("unexpected_product32");
            end else begin
                check("product32", if32.product, exp32_q.pop_front());
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send8(input logic [7:0] a, input logic [7:0] b, input bit push);
        if8.multiplicand = a;
        if8.multiplier   = b;
        if8.in_valid     = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (if8.in_ready) break;
            if (n == 199) timeout("send8_in_ready");
        end
        @(posedge clk);
        if (push) exp8_q.push_back(ref8(a, b));
        #1 if8.in_valid = 1'b0;
    endtask

    task automatic wait_valid8(output int lat);
        lat = -1;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk);
            #1;
            if (if8.out_valid) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) timeout("wait_valid8");
    endtask

    task automatic send32(input logic [31:0] a, input logic [31:0] b);
        if32.multiplicand = a;
        if32.multiplier   = b;
        if32.in_valid     = 1'b1;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (if32.in_ready) break;
            if (n == 499) timeout("send32_in_ready");
        end
        @(posedge clk);
        exp32_q.push_back(ref32(a, b));
        #1 if32.in_valid = 1'b0;
    endtask

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'h7fff_ffff;
            2:       return 32'h0000_0000;
            3:       return 32'hffff_ffff;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- main sequence ----------------
    logic [7:0]  ca [4] = '{8'h80, 8'd127, 8'h80, 8'd0};
    logic [7:0]  cb [4] = '{8'h80, 8'hff, 8'd127, 8'hb3};
    logic [15:0] creq [4] = '{16'h4000, 16'hff81, 16'hc080, 16'h0000};

    initial begin
        int          lat;
        logic [15:0] hold;

        rst = 1'b1;
        if8.in_valid  = 1'b0; if8.multiplicand  = '0; if8.multiplier  = '0; if8.out_ready  = 1'b1;
        if7.in_valid  = 1'b0; if7.multiplicand  = '0; if7.multiplier  = '0; if7.out_ready  = 1'b1;
        if32.in_valid = 1'b0; if32.multiplicand = '0; if32.multiplier = '0; if32.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  64'(if8.in_ready), 64'd1);
        check("rst_out_valid", 64'(if8.out_valid), 64'd0);
        check("rst_busy",      64'(if8.busy), 64'd0);
        check("rst_product",   64'(if8.product), 64'd0);
        check("rst_product32", if32.product, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 7 * 3 with latency and return-to-idle timing
        send8(8'd7, 8'd3, 1'b1);
        wait_valid8(lat);
        check("latency_7x3", 64'(lat), 64'd4);
        check("value_7x3", 64'(if8.product), 64'h0015);
        @(posedge clk);
        #1;
        check("in_ready_after_out", 64'(if8.in_ready), 64'd1);
        check("out_valid_after_out", 64'(if8.out_valid), 64'd0);

        // signed corners
        for (int i = 0; i < 4; i++) begin
            send8(ca[i], cb[i], 1'b1);
            wait_valid8(lat);
            check("corner_value", 64'(if8.product), 64'(creq[i]));
            @(posedge clk);
            #1;
        end

        // odd width: -64 * -64 at DATA_WIDTH=7
        if7.multiplicand = 7'h40;
        if7.multiplier   = 7'h40;
        if7.in_valid     = 1'b1;
        @(negedge clk);
        check("in_ready7", 64'(if7.in_ready), 64'd1);
        @(posedge clk);
        exp7_q.push_back(ref7(7'h40, 7'h40));
        #1 if7.in_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk);
            #1;
            if (if7.out_valid) begin
                lat = n;
                break;
            end
        end
        check("latency7", 64'(lat), 64'd4);
        check("value7", 64'(if7.product), 64'h1000);
        @(posedge clk);
        #1;

        // backpressure: product held, new operands ignored
        if8.out_ready = 1'b0;
        send8(8'hfd, 8'd9, 1'b1);
        wait_valid8(lat);
        hold = if8.product;
        check("bp_value", 64'(hold), 64'hffe5);
        for (int i = 0; i < 10; i++) begin
            if8.multiplicand = 8'($urandom);
            if8.multiplier   = 8'($urandom);
            if8.in_valid     = i[0];
            @(negedge clk);
            check("bp_stable", 64'(if8.product), 64'(hold));
            check("bp_in_ready", 64'(if8.in_ready), 64'd0);
            check("bp_out_valid", 64'(if8.out_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        if8.in_valid  = 1'b0;
        if8.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_released_valid", 64'(if8.out_valid), 64'd0);
        check("bp_released_ready", 64'(if8.in_ready), 64'd1);
        repeat (6) @(posedge clk);
        #1;
        check("bp_no_relatch", 64'(if8.busy), 64'd0);

        // reset during RUN after two digits
        send8(8'd100, 8'd100, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("mid_run_busy", 64'(if8.busy), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", 64'(if8.out_valid), 64'd0);
        check("rst_mid_in_ready",  64'(if8.in_ready), 64'd1);
        check("rst_mid_busy",      64'(if8.busy), 64'd0);
        check("rst_mid_state",     64'(if8.state), 64'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send8(8'd5, 8'hfa, 1'b1);
        wait_valid8(lat);
        check("after_rst_latency", 64'(lat), 64'd4);
        check("after_rst_value", 64'(if8.product), 64'hffe2);
        @(posedge clk);
        #1;

        // randomized 32-bit traffic with random gaps and backpressure
        fork
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 if32.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int i = 0; i < N_RAND; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send32(pick32(), pick32());
        end
        for (int n = 0; n <= 1000; n++) begin
            @(posedge clk);
            if (exp32_q.size() == 0) break;
            if (n == 1000) timeout("drain32");
        end
        done = 1'b1;
        repeat (3) @(posedge clk);

        check("count32", 64'(got32), 64'(N_RAND));
        check("q8_empty", 64'(exp8_q.size()), 64'd0);
        check("q7_empty", 64'(exp7_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
